// File: rtl/dino_pkg.sv
// -----------------------------------------------------------------------------
// dino_pkg : shared types and constants for the dino runner blocks.
//   state_t    - game state seen by obstacle_generator and collision_detector
//   COORD_W    - width of every screen coordinate / distance / height
//   H_SHORT/H_MED/H_TALL - default cactus heights
//   height_sel - maps a 2-bit random draw onto one of three heights
// -----------------------------------------------------------------------------
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2,
    WIN  = 2'd3
  } state_t;

  localparam int COORD_W = 9;

  localparam int H_SHORT = 20;
  localparam int H_MED   = 30;
  localparam int H_TALL  = 40;

  // 0 and 1 both give the short cactus, so short ones show up half the time.
  function automatic logic [COORD_W-1:0] height_sel(
    input logic [1:0]         sel,
    input logic [COORD_W-1:0] hs,
    input logic [COORD_W-1:0] hm,
    input logic [COORD_W-1:0] ht
  );
    logic [COORD_W-1:0] h;
    case (sel)
      2'd2:    h = hm;
      2'd3:    h = ht;
      default: h = hs;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/obstacle_lfsr.sv
// -----------------------------------------------------------------------------
// obstacle_lfsr : free-running 16-bit Fibonacci LFSR,
//   polynomial x^16 + x^14 + x^13 + x^11 + 1 (maximal length).
// Ports:
//   clk   - system clock
//   nrst  - asynchronous active-low reset, loads SEED
//   lfsr  - current register value
// Shifts toward the MSB; the feedback bit enters at bit 0. SEED must be
// nonzero or the register locks at zero.
// -----------------------------------------------------------------------------
module obstacle_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        nrst,
  output logic [15:0] lfsr
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  // Taps 16,14,13,11 (1-based) are bits 15,13,12,10.
  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_lfsr <= SEED;
    else       r_lfsr <= {r_lfsr[14:0], w_fb};
  end

  assign lfsr = r_lfsr;

endmodule

// File: rtl/obstacle_generator.sv
// -----------------------------------------------------------------------------
// obstacle_generator : produces the two-cactus stream for the dino game.
// Ports:
//   clk              - system clock
//   nrst             - asynchronous active-low reset
//   state            - game state (IDLE/RUN/OVER/WIN)
//   frame_tick       - one-cycle pulse per frame
//   collision_detect - collision flag; freezes the stream
//   cactusX1         - X of the leading cactus
//   cactusRandDist   - gap to trailing cactus (cactusX2 = cactusX1 + gap)
//   cactusHeight1/2  - heights of leading / trailing cactus
//   cactus_passed    - one-cycle pulse when the leading cactus retires
// Build option:
//   SPEEDUP_EN - when defined, the scroll step grows by one every 8 retired
//                cactii, saturating at 6. Otherwise the step is fixed at STEP.
// The LFSR free-runs in every state so draws depend on player timing.
// -----------------------------------------------------------------------------
module obstacle_generator #(
  parameter int          SCREEN_W  = 320,
  parameter int          MIN_DIST  = 64,
  parameter int          DIST_MASK = 63,
  parameter int          STEP      = 2,
  parameter int          H_SHORT   = dino_pkg::H_SHORT,
  parameter int          H_MED     = dino_pkg::H_MED,
  parameter int          H_TALL    = dino_pkg::H_TALL,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  dino_pkg::state_t              state,
  input  logic                          frame_tick,
  input  logic                          collision_detect,
  output logic [dino_pkg::COORD_W-1:0]  cactusX1,
  output logic [dino_pkg::COORD_W-1:0]  cactusRandDist,
  output logic [dino_pkg::COORD_W-1:0]  cactusHeight1,
  output logic [dino_pkg::COORD_W-1:0]  cactusHeight2,
  output logic                          cactus_passed
);

  import dino_pkg::*;

  localparam logic [COORD_W-1:0] C_SCREEN = COORD_W'(SCREEN_W);
  localparam logic [COORD_W-1:0] C_MIN_D  = COORD_W'(MIN_DIST);
  localparam logic [COORD_W-1:0] C_MASK   = COORD_W'(DIST_MASK);
  localparam logic [COORD_W-1:0] C_STEP   = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] C_HS     = COORD_W'(H_SHORT);
  localparam logic [COORD_W-1:0] C_HM     = COORD_W'(H_MED);
  localparam logic [COORD_W-1:0] C_HT     = COORD_W'(H_TALL);

  // ---------------------------------------------------------------------------
  // Random source
  // ---------------------------------------------------------------------------
  logic [15:0] w_lfsr;
  logic        w_unused_lfsr;

  obstacle_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .nrst (nrst),
    .lfsr (w_lfsr)
  );

  // Only the low byte feeds the draws.
  assign w_unused_lfsr = ^w_lfsr[15:COORD_W];

  logic [COORD_W-1:0] w_new_dist;
  logic [COORD_W-1:0] w_new_h;

  assign w_new_dist = C_MIN_D + (w_lfsr[COORD_W-1:0] & C_MASK);
  assign w_new_h    = height_sel(w_lfsr[7:6], C_HS, C_HM, C_HT);

  // ---------------------------------------------------------------------------
  // Scroll step
  // ---------------------------------------------------------------------------
  logic [COORD_W-1:0] w_step;

  // ---------------------------------------------------------------------------
  // Update qualification. Collision beats a simultaneous tick.
  // ---------------------------------------------------------------------------
  logic w_move;
  logic w_retire;

  assign w_move   = (state == RUN) && frame_tick && !collision_detect;
  // Retire when one more step would reach or pass the left edge; this is
  // also what keeps the subtraction from underflowing.
  assign w_retire = w_move && !(cactusX1 > w_step);

`ifdef SPEEDUP_EN
  localparam logic [COORD_W-1:0] C_STEP_MAX = COORD_W'(6);

  logic [COORD_W-1:0] r_step;
  logic [2:0]         r_pass_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_step     <= C_STEP;
      r_pass_cnt <= 3'd0;
    end else if (state == IDLE) begin
      r_step     <= C_STEP;
      r_pass_cnt <= 3'd0;
    end else if (w_retire) begin
      r_pass_cnt <= r_pass_cnt + 3'd1;
      // Counter wraps on the 8th pass: that is when the game speeds up.
      if (r_pass_cnt == 3'd7 && r_step < C_STEP_MAX)
        r_step <= r_step + COORD_W'(1);
    end
  end

  assign w_step = r_step;
`else
  assign w_step = C_STEP;
`endif

  // ---------------------------------------------------------------------------
  // Cactus state
  // ---------------------------------------------------------------------------
  logic [COORD_W-1:0] r_x1;
  logic [COORD_W-1:0] r_dist;
  logic [COORD_W-1:0] r_h1;
  logic [COORD_W-1:0] r_h2;
  logic               r_passed;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_x1     <= C_SCREEN;
      r_dist   <= C_MIN_D;
      r_h1     <= C_HS;
      r_h2     <= C_HS;
      r_passed <= 1'b0;
    end else if (state == IDLE) begin
      // Every game starts from the same layout.
      r_x1     <= C_SCREEN;
      r_dist   <= C_MIN_D;
      r_h1     <= C_HS;
      r_h2     <= C_HS;
      r_passed <= 1'b0;
    end else begin
      r_passed <= w_retire;
      if (w_retire) begin
        // Trailing cactus becomes the leader, already stepped this frame.
        r_x1   <= r_x1 + r_dist - w_step;
        r_h1   <= r_h2;
        r_dist <= w_new_dist;
        r_h2   <= w_new_h;
      end else if (w_move) begin
        r_x1   <= r_x1 - w_step;
      end
    end
  end

  assign cactusX1       = r_x1;
  assign cactusRandDist = r_dist;
  assign cactusHeight1  = r_h1;
  assign cactusHeight2  = r_h2;
  assign cactus_passed  = r_passed;

endmodule

// File: tb/tb_obstacle_generator.sv
module tb_obstacle_generator;
  import dino_pkg::*;

  localparam int          SCREEN_W  = 320;
  localparam int          MIN_DIST  = 64;
  localparam int          DIST_MASK = 63;
  localparam int          STEP      = 2;
  localparam int          HS        = 20;
  localparam int          HM        = 30;
  localparam int          HT        = 40;
  localparam logic [15:0] SEED      = 16'hACE1;

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  state_t     state = IDLE;
  logic       frame_tick = 1'b0;
  logic       collision_detect = 1'b0;
  logic [8:0] cactusX1, cactusRandDist, cactusHeight1, cactusHeight2;
  logic       cactus_passed;

  obstacle_generator dut (
    .clk              (clk),
    .nrst             (nrst),
    .state            (state),
    .frame_tick       (frame_tick),
    .collision_detect (collision_detect),
    .cactusX1         (cactusX1),
    .cactusRandDist   (cactusRandDist),
    .cactusHeight1    (cactusHeight1),
    .cactusHeight2    (cactusHeight2),
    .cactus_passed    (cactus_passed)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: what the screen should show, in plain integers.
  int          mx, md, mh1, mh2, mstep, mcnt, n_ret;
  logic [15:0] m_lfsr;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // x^16+x^14+x^13+x^11+1, shifting toward the MSB.
  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction

  function automatic int height_of(input int sel);
    if (sel == 2) return HM;
    if (sel == 3) return HT;
    return HS;
  endfunction

  task automatic model_reset();
    mx = SCREEN_W; md = MIN_DIST; mh1 = HS; mh2 = HS; mstep = STEP; mcnt = 0;
  endtask

  task automatic check_outs(input int exp_pass);
    chk("x1", cactusX1, mx);
    chk("dist", cactusRandDist, md);
    chk("h1", cactusHeight1, mh1);
    chk("h2", cactusHeight2, mh2);
    chk("passed", cactus_passed, exp_pass);
    chk("lfsr", dut.u_lfsr.lfsr, m_lfsr);
    chk("lfsr_nonzero", int'(dut.u_lfsr.lfsr != 16'd0), 1);
  endtask

  // One clock with the given inputs; model advanced from the rules, then compared.
  task automatic step(input state_t st, input bit ft, input bit col);
    int ep;
    ep = 0;
    state = st; frame_tick = ft; collision_detect = col;
    if (st == IDLE) model_reset();
    else if (st == RUN && ft && !col) begin
      if (mx > mstep) mx = mx - mstep;
      else begin
        mx  = mx + md - mstep;
        mh1 = mh2;
        md  = MIN_DIST + (int'(m_lfsr) & DIST_MASK);
        mh2 = height_of((int'(m_lfsr) >> 6) & 3);
        ep  = 1;
        n_ret++;
`ifdef SPEEDUP_EN
        mcnt = (mcnt + 1) % 8;
        if (mcnt == 0 && mstep < 6) mstep++;
`endif
      end
    end
    @(posedge clk); #1;
    m_lfsr = lfsr_adv(m_lfsr);
    check_outs(ep);
    if (ep == 1) begin
      chk("dist_range", int'(cactusRandDist >= 9'd64 && cactusRandDist <= 9'd127), 1);
      chk("x2_max", int'(int'(cactusX1) + int'(cactusRandDist) <= 447), 1);
    end
  endtask

  task automatic tick_until_retires(input int cnt);
    int target, guard;
    target = n_ret + cnt;
    guard  = 0;
    while (n_ret < target && guard < 20000) begin
      step(RUN, 1'b1, 1'b0);
      guard++;
    end
    chk("retire_budget", int'(n_ret >= target), 1);
  endtask

  int xb, target, guard, exp_step;

  initial begin
    n_ret = 0;
    model_reset();
    // Asynchronous reset, asserted between clock edges.
    #1 nrst = 1'b0;
    #1;
    m_lfsr = SEED;
    check_outs(0);
    #1 nrst = 1'b1;

    step(IDLE, 1'b0, 1'b0);
    step(IDLE, 1'b1, 1'b0);

    // Plain scrolling: 10 ticks with idle cycles between.
    for (int i = 0; i < 10; i++) begin
      step(RUN, 1'b1, 1'b0);
      step(RUN, 1'b0, 1'b0);
    end
    chk("x_after_10", cactusX1, 300);
    chk("dist_after_10", cactusRandDist, 64);

    // Scroll to the left edge and retire the first cactus.
    guard = 0;
    while (mx != 2 && guard < 400) begin step(RUN, 1'b1, 1'b0); guard++; end
    chk("reach_x2", cactusX1, 2);
    step(RUN, 1'b1, 1'b0);
    chk("retire_x", cactusX1, 64);
    chk("retire_h1", cactusHeight1, 20);
    chk("retire_pass", cactus_passed, 1);
    step(RUN, 1'b0, 1'b0);
    chk("pass_one_cycle", cactus_passed, 0);

    // Collision wins over a simultaneous tick; OVER freezes; IDLE reloads.
    for (int i = 0; i < 7; i++) step(RUN, 1'b1, 1'b0);
    xb = cactusX1;
    step(RUN, 1'b1, 1'b1);
    chk("collision_hold", cactusX1, xb);
    for (int i = 0; i < 5; i++) step(OVER, 1'b1, 1'b0);
    chk("over_frozen", cactusX1, xb);
    for (int i = 0; i < 3; i++) step(WIN, 1'b1, 1'b0);
    step(IDLE, 1'b0, 1'b0);
    chk("idle_reload_x", cactusX1, 320);
    chk("idle_reload_h1", cactusHeight1, 20);
    chk("idle_reload_h2", cactusHeight2, 20);

    // Reset in the middle of RUN returns immediately to reset values.
    for (int i = 0; i < 13; i++) step(RUN, 1'b1, 1'b0);
    #2 nrst = 1'b0;
    #1;
    model_reset();
    m_lfsr = SEED;
    check_outs(0);
    #1 nrst = 1'b1;

    // Randomized play: 200 retires with random tick spacing and interruptions.
    step(IDLE, 1'b0, 1'b0);
    target = n_ret + 200;
    guard  = 0;
    while (n_ret < target && guard < 60000) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 3) begin
        for (int k = 0; k < 3; k++) step(OVER, $urandom_range(0, 1) == 1, 1'b0);
      end else if (r < 5) begin
        step(WIN, 1'b1, 1'b0);
      end else begin
        step(RUN, $urandom_range(0, 2) != 0, $urandom_range(0, 59) == 0);
      end
      guard++;
    end
    chk("random_budget", int'(n_ret >= target), 1);

`ifdef SPEEDUP_EN
    exp_step = 6;
`else
    exp_step = STEP;
`endif
    // Observed step after many retires.
    while (mx <= 6) step(RUN, 1'b1, 1'b0);
    xb = cactusX1;
    step(RUN, 1'b1, 1'b0);
    chk("step_late", xb - int'(cactusX1), exp_step);

    // Fresh game: 8 retires, then the step is one larger when speedup is built in.
    step(IDLE, 1'b0, 1'b0);
    tick_until_retires(8);
    while (mx <= 6) step(RUN, 1'b1, 1'b0);
    xb = cactusX1;
    step(RUN, 1'b1, 1'b0);
`ifdef SPEEDUP_EN
    exp_step = 3;
`else
    exp_step = STEP;
`endif
    chk("step_after_8", xb - int'(cactusX1), exp_step);

    // 32 retires from a fresh game reach the cap; 8 more keep it there.
    step(IDLE, 1'b0, 1'b0);
    tick_until_retires(40);
    while (mx <= 6) step(RUN, 1'b1, 1'b0);
    xb = cactusX1;
    step(RUN, 1'b1, 1'b0);
`ifdef SPEEDUP_EN
    exp_step = 6;
`else
    exp_step = STEP;
`endif
    chk("step_saturated", xb - int'(cactusX1), exp_step);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
